load_align_unit: RTL and testbench

Parametrised load-data path between the core's MEM stage and the data memory (DTCM) bus. It generalises the current combinational sign/zero-extend stage to XLEN = 32 or 64. It adds byte-lane alignment on the access address and a valid/ready memory handshake. It optionally splits an access that crosses a bus word into two bus beats. One load is in flight at a time; the result is returned with a single-cycle response pulse.

---
 rtl/load_align_unit.sv | 186 ++++++++++++++++++
 tb/tb_load_align_unit.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_align_unit.sv
// load_align_unit
//
// Load-data path between the MEM stage and the DTCM read bus. It accepts one
// load at a time and fetches the containing bus word. A load that crosses into
// the next word is either fetched as a second beat or faulted, depending on
// MISALIGN_EN. The selected bytes are then sign- or zero-extended to XLEN and
// returned as a one-cycle response pulse.
//
// Parameters
//   XLEN        data / bus width, 32 or 64
//   AW          address width
//   MISALIGN_EN 1: split word-crossing loads into two beats, 0: fault them
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   ld_req_valid / ld_req_ready   load request handshake from the MEM stage
//   ld_addr, RW_type              byte address and funct3 of the load
//   ld_rsp_valid                  one-cycle result pulse
//   ld_rsp_data, ld_rsp_fault     registered result, held until the next response
//   mem_req_valid / mem_req_ready bus read request handshake
//   mem_addr                      word-aligned bus address
//   mem_rsp_valid, mem_rsp_data   bus read data
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | ready for a new load
// REQ0  | bus request for the word holding the first byte
// WAIT0 | waiting for beat 0 read data
// REQ1  | bus request for the following word (crossing loads only)
// WAIT1 | waiting for beat 1 read data
// RESP  | response pulse, result registers already updated
module load_align_unit #(
    parameter int XLEN        = 32,
    parameter int AW          = 32,
    parameter bit MISALIGN_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ld_req_valid,
    output logic            ld_req_ready,
    input  logic [AW-1:0]   ld_addr,
    input  logic [2:0]      RW_type,
    output logic            ld_rsp_valid,
    output logic [XLEN-1:0] ld_rsp_data,
    output logic            ld_rsp_fault,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [AW-1:0]   mem_addr,
    input  logic            mem_rsp_valid,
    input  logic [XLEN-1:0] mem_rsp_data
);
    localparam int NB = XLEN / 8;
    localparam int OB = $clog2(NB);

    typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP} state_t;

    state_t          state, state_nxt;
    logic [AW-1:0]   base_q;
    logic [OB-1:0]   off_q;
    logic [2:0]      type_q;
    logic            cross_q;
    logic [XLEN-1:0] beat0_q;
    logic [XLEN-1:0] data_q;
    logic            fault_q;

    logic            req_illegal;
    logic            req_cross;
    logic            req_fault;
    logic [XLEN-1:0] load_data;

    // Shift the two-beat window down to the addressed byte, keep 8<<size bits
    // and extend from the top kept bit (forced to 0 for unsigned types).
    function automatic logic [XLEN-1:0] extend(input logic [2*XLEN-1:0] pair,
                                               input logic [OB-1:0]     off,
                                               input logic [2:0]        typ);
        logic [2*XLEN-1:0] sh;
        logic [XLEN-1:0]   res;
        logic              msb;
        int                nbits;
        sh    = pair >> {off, 3'b000};
        nbits = 8 << typ[1:0];
        case (typ[1:0])
            2'b00:   msb = sh[7];
            2'b01:   msb = sh[15];
            2'b10:   msb = sh[31];
            default: msb = sh[XLEN-1];
        endcase
        msb = msb & ~typ[2];
        for (int i = 0; i < XLEN; i++) begin
            res[i] = (i < nbits) ? sh[i] : msb;
        end
        return res;
    endfunction

    // On a 32-bit datapath any size-8 encoding is illegal, which covers 011 and 111.
    always_comb begin
        req_illegal = (RW_type == 3'b111) ||
                      ((XLEN == 32) && ((RW_type[1:0] == 2'b11) || (RW_type == 3'b110)));
        req_cross   = (int'(ld_addr[OB-1:0]) + (1 << RW_type[1:0])) > NB;
        req_fault   = req_illegal || (req_cross && !MISALIGN_EN);
    end

    always_comb begin
        if (state == WAIT1) begin
            load_data = extend({mem_rsp_data, beat0_q}, off_q, type_q);
        end else begin
            load_data = extend({{XLEN{1'b0}}, mem_rsp_data}, off_q, type_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            base_q  <= '0;
            off_q   <= '0;
            type_q  <= '0;
            cross_q <= 1'b0;
            beat0_q <= '0;
            data_q  <= '0;
            fault_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && ld_req_valid) begin
                base_q  <= {ld_addr[AW-1:OB], {OB{1'b0}}};
                off_q   <= ld_addr[OB-1:0];
                type_q  <= RW_type;
                cross_q <= req_cross;
                if (req_fault) begin
                    data_q  <= '0;
                    fault_q <= 1'b1;
                end
            end
            if (state == WAIT0 && mem_rsp_valid) begin
                beat0_q <= mem_rsp_data;
                if (!cross_q) begin
                    data_q  <= load_data;
                    fault_q <= 1'b0;
                end
            end
            if (state == WAIT1 && mem_rsp_valid) begin
                data_q  <= load_data;
                fault_q <= 1'b0;
            end
        end
    end

    // Outputs are forced inactive while rst is high so an aborted load cannot
    // leak a request or response during the reset cycle itself.
    always_comb begin
        state_nxt     = state;
        ld_req_ready  = 1'b0;
        mem_req_valid = 1'b0;
        ld_rsp_valid  = 1'b0;
        mem_addr      = base_q;
        case (state)
            IDLE: begin
                ld_req_ready = !rst;
                if (ld_req_valid) state_nxt = req_fault ? RESP : REQ0;
            end
            REQ0: begin
                mem_req_valid = !rst;
                if (mem_req_ready) state_nxt = WAIT0;
            end
            WAIT0: begin
                if (mem_rsp_valid) state_nxt = cross_q ? REQ1 : RESP;
            end
            REQ1: begin
                mem_req_valid = !rst;
                mem_addr      = base_q + AW'(NB);
                if (mem_req_ready) state_nxt = WAIT1;
            end
            WAIT1: begin
                if (mem_rsp_valid) state_nxt = RESP;
            end
            RESP: begin
                ld_rsp_valid = !rst;
                state_nxt    = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign ld_rsp_data  = rst ? '0 : data_q;
    assign ld_rsp_fault = fault_q && !rst;

endmodule

// File: tb/tb_load_align_unit.sv
// tb_load_align_unit
//
// Directed bench for load_align_unit. Three instances share clock and reset:
// unit 0 is XLEN=32 with split loads enabled, unit 1 is XLEN=32 with
// misalignment faulting, unit 2 is XLEN=64 with split loads enabled.
// A small bus responder inside do_load answers each accepted read request one
// cycle later with the word supplied by the scenario.
module tb_load_align_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid  [3];
    logic [31:0] req_addr   [3];
    logic [2:0]  req_type   [3];
    logic        req_ready  [3];
    logic        rsp_valid  [3];
    logic        rsp_fault  [3];
    logic        mreq_valid [3];
    logic        mreq_ready [3];
    logic [31:0] maddr      [3];
    logic        mrsp_valid [3];
    logic [63:0] mrsp_data  [3];
    logic [31:0] rd0, rd1;
    logic [63:0] rd2;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    load_align_unit #(.XLEN(32), .AW(32), .MISALIGN_EN(1'b1)) u0 (
        .clk(clk), .rst(rst),
        .ld_req_valid(req_valid[0]), .ld_req_ready(req_ready[0]),
        .ld_addr(req_addr[0]), .RW_type(req_type[0]),
        .ld_rsp_valid(rsp_valid[0]), .ld_rsp_data(rd0), .ld_rsp_fault(rsp_fault[0]),
        .mem_req_valid(mreq_valid[0]), .mem_req_ready(mreq_ready[0]), .mem_addr(maddr[0]),
        .mem_rsp_valid(mrsp_valid[0]), .mem_rsp_data(mrsp_data[0][31:0])
    );

    load_align_unit #(.XLEN(32), .AW(32), .MISALIGN_EN(1'b0)) u1 (
        .clk(clk), .rst(rst),
        .ld_req_valid(req_valid[1]), .ld_req_ready(req_ready[1]),
        .ld_addr(req_addr[1]), .RW_type(req_type[1]),
        .ld_rsp_valid(rsp_valid[1]), .ld_rsp_data(rd1), .ld_rsp_fault(rsp_fault[1]),
        .mem_req_valid(mreq_valid[1]), .mem_req_ready(mreq_ready[1]), .mem_addr(maddr[1]),
        .mem_rsp_valid(mrsp_valid[1]), .mem_rsp_data(mrsp_data[1][31:0])
    );

    load_align_unit #(.XLEN(64), .AW(32), .MISALIGN_EN(1'b1)) u2 (
        .clk(clk), .rst(rst),
        .ld_req_valid(req_valid[2]), .ld_req_ready(req_ready[2]),
        .ld_addr(req_addr[2]), .RW_type(req_type[2]),
        .ld_rsp_valid(rsp_valid[2]), .ld_rsp_data(rd2), .ld_rsp_fault(rsp_fault[2]),
        .mem_req_valid(mreq_valid[2]), .mem_req_ready(mreq_ready[2]), .mem_addr(maddr[2]),
        .mem_rsp_valid(mrsp_valid[2]), .mem_rsp_data(mrsp_data[2])
    );

    function automatic logic [63:0] rdata(input int u);
        case (u)
            0:       return {32'h0, rd0};
            1:       return {32'h0, rd1};
            default: return rd2;
        endcase
    endfunction

    // Issue one load on unit u and play the bus. lat is the cycle (edge 0 =
    // acceptance) in which ld_rsp_valid was seen, -1 if it never came.
    task automatic do_load(input int u, input logic [31:0] a, input logic [2:0] t,
                           input logic [63:0] w0, input logic [63:0] w1, input int stall,
                           output logic [63:0] d, output logic f, output int lat,
                           output int nreq, output logic [31:0] a0, output logic [31:0] a1,
                           output int unstable, output logic rdy0);
        logic        pend;
        logic [63:0] nxt;
        logic [31:0] first_a;
        int          waited;
        pend = 1'b0; nxt = '0; first_a = '0; waited = 0;
        d = '0; f = 1'b0; lat = -1; nreq = 0; a0 = '0; a1 = '0; unstable = 0;
        @(negedge clk);
        rdy0 = req_ready[u];
        req_valid[u] = 1'b1;
        req_addr[u]  = a;
        req_type[u]  = t;
        for (int cyc = 1; cyc <= 40 && lat < 0; cyc++) begin
            @(negedge clk);
            req_valid[u] = 1'b0;
            if (rsp_valid[u]) begin
                lat = cyc;
                f   = rsp_fault[u];
                d   = rdata(u);
            end
            mrsp_valid[u] = pend;
            mrsp_data[u]  = pend ? nxt : 64'hBAD0_BAD0_BAD0_BAD0;
            pend = 1'b0;
            mreq_ready[u] = 1'b0;
            if (mreq_valid[u]) begin
                if (nreq == 0 && waited < stall) begin
                    if (waited == 0) first_a = maddr[u];
                    else if (maddr[u] != first_a) unstable++;
                    waited++;
                end else begin
                    if (nreq == 0 && stall > 0 && maddr[u] != first_a) unstable++;
                    if (nreq == 0) a0 = maddr[u];
                    else a1 = maddr[u];
                    nxt = (nreq == 0) ? w0 : w1;
                    nreq++;
                    pend = 1'b1;
                    mreq_ready[u] = 1'b1;
                end
            end
        end
        mrsp_valid[u] = 1'b0;
        mreq_ready[u] = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_chk++; if (req_ready[0] !== 1'b0) $display("FAIL rst_ready: got %b want 0", req_ready[0]); else n_pass++;
        n_chk++; if (mreq_valid[0] !== 1'b0) $display("FAIL rst_mreq: got %b want 0", mreq_valid[0]); else n_pass++;
        n_chk++; if (rsp_valid[0] !== 1'b0) $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid[0]); else n_pass++;
        n_chk++; if (rsp_fault[0] !== 1'b0) $display("FAIL rst_fault: got %b want 0", rsp_fault[0]); else n_pass++;
        n_chk++; if (rd0 !== 32'h0) $display("FAIL rst_data: got %h want 0", rd0); else n_pass++;
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            n_chk++; if (req_ready[i] !== 1'b1) $display("FAIL post_rst_ready%0d: got %b want 1", i, req_ready[i]); else n_pass++;
            n_chk++; if (mreq_valid[i] !== 1'b0) $display("FAIL post_rst_mreq%0d: got %b want 0", i, mreq_valid[i]); else n_pass++;
        end
    endtask

    task automatic test_byte();
        logic [63:0] d; logic f, r; int lat, nr, us; logic [31:0] a0, a1;
        do_load(0, 32'h103, 3'b000, 64'h80FF1234, 64'h0, 0, d, f, lat, nr, a0, a1, us, r);
        n_chk++; if (d !== 64'hFFFFFF80) $display("FAIL lb_data: got %h want FFFFFF80", d); else n_pass++;
        n_chk++; if (f !== 1'b0) $display("FAIL lb_fault: got %b want 0", f); else n_pass++;
        n_chk++; if (lat !== 3) $display("FAIL lb_latency: got %0d want 3", lat); else n_pass++;
        n_chk++; if (nr !== 1) $display("FAIL lb_nreq: got %0d want 1", nr); else n_pass++;
        n_chk++; if (a0 !== 32'h100) $display("FAIL lb_maddr: got %h want 100", a0); else n_pass++;
        @(negedge clk);
        n_chk++; if (rsp_valid[0] !== 1'b0) $display("FAIL lb_pulse: got %b want 0", rsp_valid[0]); else n_pass++;
        n_chk++; if (rd0 !== 32'hFFFFFF80) $display("FAIL lb_hold: got %h want FFFFFF80", rd0); else n_pass++;
        do_load(0, 32'h103, 3'b100, 64'h80FF1234, 64'h0, 0, d, f, lat, nr, a0, a1, us, r);
        n_chk++; if (d !== 64'h00000080) $display("FAIL lbu_data: got %h want 00000080", d); else n_pass++;
        n_chk++; if (nr !== 1 || a0 !== 32'h100) $display("FAIL lbu_bus: got nreq %0d addr %h want 1 100", nr, a0); else n_pass++;
    endtask

    task automatic test_half();
        logic [63:0] d; logic f, r; int lat, nr, us; logic [31:0] a0, a1;
        do_load(0, 32'h102, 3'b001, 64'hA5B67788, 64'h0, 0, d, f, lat, nr, a0, a1, us, r);
        n_chk++; if (d !== 64'hFFFFA5B6) $display("FAIL lh_data: got %h want FFFFA5B6", d); else n_pass++;
        do_load(0, 32'h102, 3'b101, 64'hA5B67788, 64'h0, 0, d, f, lat, nr, a0, a1, us, r);
        n_chk++; if (d !== 64'h0000A5B6) $display("FAIL lhu_data: got %h want 0000A5B6", d); else n_pass++;
        do_load(0, 32'h101, 3'b001, 64'h00C3D400, 64'h0, 0, d, f, lat, nr, a0, a1, us, r);
        n_chk++; if (d !== 64'hFFFFC3D4) $display("FAIL lh_off1_data: got %h want FFFFC3D4", d); else n_pass++;
        n_chk++; if (nr !== 1 || lat !== 3) $display("FAIL lh_off1_beats: got nreq %0d lat %0d want 1 3", nr, lat); else n_pass++;
    endtask

    task automatic test_split();
        logic [63:0] d; logic f, r; int lat, nr, us; logic [31:0] a0, a1;
        do_load(0, 32'h202, 3'b010, 64'h44332211, 64'h88776655, 0, d, f, lat, nr, a0, a1, us, r);
        n_chk++; if (d !== 64'h66554433) $display("FAIL split_data: got %h want 66554433", d); else n_pass++;
        n_chk++; if (nr !== 2) $display("FAIL split_nreq: got %0d want 2", nr); else n_pass++;
        n_chk++; if (a0 !== 32'h200 || a1 !== 32'h204) $display("FAIL split_addr: got %h %h want 200 204", a0, a1); else n_pass++;
        n_chk++; if (lat !== 5) $display("FAIL split_latency: got %0d want 5", lat); else n_pass++;
        do_load(0, 32'hFFFF_FFFE, 3'b010, 64'hBBAA1111, 64'h2222DDCC, 0, d, f, lat, nr, a0, a1, us, r);
        n_chk++; if (a0 !== 32'hFFFF_FFFC || a1 !== 32'h0) $display("FAIL wrap_addr: got %h %h want FFFFFFFC 0", a0, a1); else n_pass++;
        n_chk++; if (d !== 64'hDDCCBBAA) $display("FAIL wrap_data: got %h want DDCCBBAA", d); else n_pass++;
    endtask

    task automatic test_fault();
        logic [63:0] d; logic f, r; int lat, nr, us; logic [31:0] a0, a1;
        do_load(1, 32'h202, 3'b010, 64'h44332211, 64'h88776655, 0, d, f, lat, nr, a0, a1, us, r);
        n_chk++; if (f !== 1'b1 || d !== 64'h0) $display("FAIL nomis_fault: got f %b d %h want 1 0", f, d); else n_pass++;
        n_chk++; if (lat !== 1 || nr !== 0) $display("FAIL nomis_timing: got lat %0d nreq %0d want 1 0", lat, nr); else n_pass++;
        // unit 0 holds a nonzero result from the previous load; the fault must clear it
        do_load(0, 32'h100, 3'b011, 64'h12345678, 64'h0, 0, d, f, lat, nr, a0, a1, us, r);
        n_chk++; if (f !== 1'b1 || d !== 64'h0) $display("FAIL ld32_fault: got f %b d %h want 1 0", f, d); else n_pass++;
        n_chk++; if (lat !== 1 || nr !== 0) $display("FAIL ld32_timing: got lat %0d nreq %0d want 1 0", lat, nr); else n_pass++;
        do_load(0, 32'h100, 3'b110, 64'h12345678, 64'h0, 0, d, f, lat, nr, a0, a1, us, r);
        n_chk++; if (f !== 1'b1 || nr !== 0) $display("FAIL lwu32_fault: got f %b nreq %0d want 1 0", f, nr); else n_pass++;
        do_load(0, 32'h100, 3'b111, 64'h12345678, 64'h0, 0, d, f, lat, nr, a0, a1, us, r);
        n_chk++; if (f !== 1'b1 || nr !== 0) $display("FAIL t111_fault: got f %b nreq %0d want 1 0", f, nr); else n_pass++;
    endtask

    task automatic test_stall();
        logic [63:0] d; logic f, r; int lat, nr, us; logic [31:0] a0, a1;
        do_load(0, 32'h300, 3'b010, 64'h12345678, 64'h0, 3, d, f, lat, nr, a0, a1, us, r);
        n_chk++; if (lat !== 6) $display("FAIL stall_latency: got %0d want 6", lat); else n_pass++;
        n_chk++; if (us !== 0 || a0 !== 32'h300) $display("FAIL stall_addr: got changes %0d addr %h want 0 300", us, a0); else n_pass++;
        n_chk++; if (d !== 64'h12345678 || f !== 1'b0) $display("FAIL stall_data: got %h f %b want 12345678 0", d, f); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [63:0] d; logic f, r; int lat, nr, us; logic [31:0] a0, a1;
        do_load(0, 32'h400, 3'b000, 64'h000000F1, 64'h0, 0, d, f, lat, nr, a0, a1, us, r);
        do_load(0, 32'h401, 3'b100, 64'h0000C200, 64'h0, 0, d, f, lat, nr, a0, a1, us, r);
        n_chk++; if (r !== 1'b1) $display("FAIL b2b_ready: got %b want 1", r); else n_pass++;
        n_chk++; if (d !== 64'h000000C2 || lat !== 3) $display("FAIL b2b_second: got %h lat %0d want C2 3", d, lat); else n_pass++;
    endtask

    task automatic test_reset_abort();
        int rsp_seen;
        rsp_seen = 0;
        @(negedge clk);
        req_valid[0] = 1'b1; req_addr[0] = 32'h500; req_type[0] = 3'b010;
        @(negedge clk);
        req_valid[0] = 1'b0;
        mreq_ready[0] = 1'b1;
        @(negedge clk);
        n_chk++; if (mreq_valid[0] !== 1'b0) $display("FAIL abort_in_wait: got mreq %b want 0", mreq_valid[0]); else n_pass++;
        mreq_ready[0] = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        mrsp_valid[0] = 1'b1;
        mrsp_data[0]  = 64'h0000_0000_CAFE_F00D;
        for (int i = 0; i < 3; i++) begin
            if (rsp_valid[0]) rsp_seen++;
            @(negedge clk);
            mrsp_valid[0] = 1'b0;
        end
        n_chk++; if (rsp_seen !== 0) $display("FAIL abort_rsp: got %0d pulses want 0", rsp_seen); else n_pass++;
        n_chk++; if (req_ready[0] !== 1'b1) $display("FAIL abort_ready: got %b want 1", req_ready[0]); else n_pass++;
        n_chk++; if (mreq_valid[0] !== 1'b0) $display("FAIL abort_mreq: got %b want 0", mreq_valid[0]); else n_pass++;
    endtask

    task automatic test_xlen64();
        logic [63:0] d; logic f, r; int lat, nr, us; logic [31:0] a0, a1;
        do_load(2, 32'h1004, 3'b110, 64'hDEADBEEF_00000000, 64'h0, 0, d, f, lat, nr, a0, a1, us, r);
        n_chk++; if (d !== 64'h00000000_DEADBEEF) $display("FAIL x64_lwu: got %h want 00000000DEADBEEF", d); else n_pass++;
        n_chk++; if (a0 !== 32'h1000 || nr !== 1) $display("FAIL x64_lwu_bus: got %h nreq %0d want 1000 1", a0, nr); else n_pass++;
        do_load(2, 32'h1004, 3'b010, 64'hDEADBEEF_00000000, 64'h0, 0, d, f, lat, nr, a0, a1, us, r);
        n_chk++; if (d !== 64'hFFFFFFFF_DEADBEEF) $display("FAIL x64_lw: got %h want FFFFFFFFDEADBEEF", d); else n_pass++;
        do_load(2, 32'h1000, 3'b011, 64'hDEADBEEF_00000000, 64'h0, 0, d, f, lat, nr, a0, a1, us, r);
        n_chk++; if (d !== 64'hDEADBEEF_00000000 || f !== 1'b0) $display("FAIL x64_ld: got %h f %b want DEADBEEF00000000 0", d, f); else n_pass++;
        do_load(2, 32'h1007, 3'b001, 64'hAB00_0000_0000_0000, 64'h0000_0000_0000_00CD, 0, d, f, lat, nr, a0, a1, us, r);
        n_chk++; if (d !== 64'hFFFF_FFFF_FFFF_CDAB) $display("FAIL x64_split_data: got %h want FFFFFFFFFFFFCDAB", d); else n_pass++;
        n_chk++; if (a0 !== 32'h1000 || a1 !== 32'h1008 || lat !== 5) $display("FAIL x64_split_bus: got %h %h lat %0d want 1000 1008 5", a0, a1, lat); else n_pass++;
        do_load(2, 32'h1000, 3'b111, 64'h0, 64'h0, 0, d, f, lat, nr, a0, a1, us, r);
        n_chk++; if (f !== 1'b1 || nr !== 0 || lat !== 1) $display("FAIL x64_t111: got f %b nreq %0d lat %0d want 1 0 1", f, nr, lat); else n_pass++;
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req_valid[i]  = 1'b0;
            req_addr[i]   = '0;
            req_type[i]   = '0;
            mreq_ready[i] = 1'b0;
            mrsp_valid[i] = 1'b0;
            mrsp_data[i]  = '0;
        end
        test_reset();
        test_byte();
        test_half();
        test_split();
        test_fault();
        test_stall();
        test_back_to_back();
        test_reset_abort();
        test_xlen64();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
